// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare predictor: saturating counter arithmetic
// and the BTB entry layout.
package bp_pkg;

   localparam int CTR_W_MAX   = 32;
   // Widest tag a BTB can need (2-entry BTB); narrower tags are zero-extended into it.
   localparam int BTB_TAG_MAX = 29;

   function automatic logic [CTR_W_MAX-1:0] ctr_max(input int width);
      return (width >= CTR_W_MAX) ? {CTR_W_MAX{1'b1}} : ((32'd1 << width) - 32'd1);
   endfunction

   function automatic logic [CTR_W_MAX-1:0] sat_inc(input logic [CTR_W_MAX-1:0] value,
                                                    input int width);
      return (value >= ctr_max(width)) ? ctr_max(width) : value + 32'd1;
   endfunction

   function automatic logic [CTR_W_MAX-1:0] sat_dec(input logic [CTR_W_MAX-1:0] value,
                                                    input int width);
      return (value == '0) ? '0 : value - 32'd1;
   endfunction

   // Weakly-not-taken: 2^(width-1)-1, i.e. the largest value whose MSB is clear.
   function automatic logic [CTR_W_MAX-1:0] wnt_init(input int width);
      return ctr_max(width) >> 1;
   endfunction

   typedef struct packed {
      logic                   valid;
      logic [BTB_TAG_MAX-1:0] tag;
      logic [31:0]            target;
   } btb_entry_t;

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch-side prediction and execute-side resolution signals of the gshare predictor.
// Signal suffixes are named from the predictor's point of view.
interface branch_predictor_gshare_if #(
   parameter int GHR_BITS = 8
) ();

   logic                fetch_valid_i;
   logic [31:0]         fetch_pc_i;
   logic                predict_taken_o;
   logic [31:0]         predict_target_o;
   logic                btb_hit_o;
   logic [GHR_BITS-1:0] predict_ghr_o;
   logic                execute_valid_i;
   logic [31:0]         execute_pc_i;
   logic [GHR_BITS-1:0] execute_ghr_i;
   logic                execute_taken_i;
   logic [31:0]         execute_target_i;
   logic                execute_mispredict_i;

   modport master (
      output fetch_valid_i, fetch_pc_i,
      output execute_valid_i, execute_pc_i, execute_ghr_i,
      output execute_taken_i, execute_target_i, execute_mispredict_i,
      input  predict_taken_o, predict_target_o, btb_hit_o, predict_ghr_o
   );

   modport slave (
      input  fetch_valid_i, fetch_pc_i,
      input  execute_valid_i, execute_pc_i, execute_ghr_i,
      input  execute_taken_i, execute_target_i, execute_mispredict_i,
      output predict_taken_o, predict_target_o, btb_hit_o, predict_ghr_o
   );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup, one write port that
// overwrites whatever occupies the slot. Reads never see a same-cycle write.
module branch_target_buffer
   import bp_pkg::*;
#(
   parameter int BTB_ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rd_pc_i,
   output logic        hit_o,
   output logic [31:0] target_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_pc_i,
   input  logic [31:0] wr_target_i
);

   localparam int IW = $clog2(BTB_ENTRIES);

   btb_entry_t    btb_q [BTB_ENTRIES];
   btb_entry_t    rd_entry;
   btb_entry_t    wr_entry;
   logic [IW-1:0] rd_idx;
   logic [IW-1:0] wr_idx;
   logic          unused_pc_bits;

   assign rd_idx   = rd_pc_i[IW+1:2];
   assign wr_idx   = wr_pc_i[IW+1:2];
   assign rd_entry = btb_q[rd_idx];
   assign hit_o    = rd_entry.valid && (rd_entry.tag == BTB_TAG_MAX'(rd_pc_i[31:IW+2]));
   assign target_o = rd_entry.target;

   assign wr_entry = '{valid: 1'b1, tag: BTB_TAG_MAX'(wr_pc_i[31:IW+2]), target: wr_target_i};

   // Instruction alignment makes the low PC bits meaningless here.
   assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: only the valid bits get a reset value; tag and target are ignored until valid is set.
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_q[i].valid <= 1'b0;
         end
      end else if (wr_en_i) begin
         btb_q[wr_idx] <= wr_entry;
      end
   end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor plus BTB target lookup for fetch, trained and
// history-repaired by resolved branches from execute.
module branch_predictor_gshare
   import bp_pkg::*;
#(
   parameter int PHT_ENTRIES = 256,
   parameter int CTR_BITS    = 2,
   parameter int GHR_BITS    = 8,
   parameter int BTB_ENTRIES = 64
) (
   input logic                      clk,
   input logic                      rst_n,
   branch_predictor_gshare_if.slave bp
);

   localparam int                  IDX     = $clog2(PHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(wnt_init(CTR_BITS));

   logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;
   logic [IDX-1:0]      fetch_idx;
   logic [IDX-1:0]      exec_idx;
   logic [CTR_BITS-1:0] fetch_ctr;
   logic [CTR_BITS-1:0] exec_ctr_d;
   logic                btb_hit;
   logic [31:0]         btb_target;
   logic                predict_taken;

   branch_target_buffer #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_pc_i     (bp.fetch_pc_i),
      .hit_o       (btb_hit),
      .target_o    (btb_target),
      .wr_en_i     (bp.execute_valid_i && bp.execute_taken_i),
      .wr_pc_i     (bp.execute_pc_i),
      .wr_target_i (bp.execute_target_i)
   );

   // Execute indexes with the history its branch saw at fetch, not the current one.
   assign fetch_idx = bp.fetch_pc_i[IDX+1:2] ^ IDX'(ghr_q);
   assign exec_idx  = bp.execute_pc_i[IDX+1:2] ^ IDX'(bp.execute_ghr_i);
   assign fetch_ctr = pht_q[fetch_idx];

   assign predict_taken       = btb_hit && fetch_ctr[CTR_BITS-1];
   assign bp.btb_hit_o        = btb_hit;
   assign bp.predict_taken_o  = predict_taken;
   assign bp.predict_target_o = predict_taken ? btb_target : bp.fetch_pc_i + 32'd4;
   assign bp.predict_ghr_o    = ghr_q;

   assign exec_ctr_d = bp.execute_taken_i
                     ? CTR_BITS'(sat_inc(CTR_W_MAX'(pht_q[exec_idx]), CTR_BITS))
                     : CTR_BITS'(sat_dec(CTR_W_MAX'(pht_q[exec_idx]), CTR_BITS));

   always_comb begin
      // NOTE: default first so every path assigns ghr_d and no latch is inferred.
      ghr_d = ghr_q;
      if (bp.execute_valid_i && bp.execute_mispredict_i) begin
         ghr_d = GHR_BITS'({bp.execute_ghr_i, bp.execute_taken_i});
      end else if (bp.fetch_valid_i && btb_hit) begin
         ghr_d = GHR_BITS'({ghr_q, predict_taken});
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register samples pre-edge values (fetch never sees the update).
      if (!rst_n) begin
         ghr_q <= '0;
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_q[i] <= CTR_WNT;
         end
      end else begin
         ghr_q <= ghr_d;
         if (bp.execute_valid_i) begin
            pht_q[exec_idx] <= exec_ctr_d;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: stimulus pushes the hand-computed prediction for every valid fetch,
// a negedge monitor pops and compares.
module tb_branch_predictor_gshare;

   localparam int GHR_BITS = 8;

   typedef struct {
      logic                hit;
      logic                taken;
      logic [31:0]         target;
      logic [GHR_BITS-1:0] ghr;
      string               name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   branch_predictor_gshare_if #(.GHR_BITS(GHR_BITS)) bus ();

   branch_predictor_gshare #(
      .PHT_ENTRIES (256),
      .CTR_BITS    (2),
      .GHR_BITS    (GHR_BITS),
      .BTB_ENTRIES (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bus)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got {hit,taken,target,ghr}=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every valid fetch presents a prediction that must match the next expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.fetch_valid_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_fetch: pc=%h has no expectation", bus.fetch_pc_i);
         end else begin
            mon_e = exp_q.pop_front();
            check(mon_e.name,
                  64'({bus.btb_hit_o, bus.predict_taken_o, bus.predict_target_o, bus.predict_ghr_o}),
                  64'({mon_e.hit, mon_e.taken, mon_e.target, mon_e.ghr}));
         end
      end
   end

   task automatic idle();
      bus.fetch_valid_i        = 1'b0;
      bus.fetch_pc_i           = '0;
      bus.execute_valid_i      = 1'b0;
      bus.execute_pc_i         = '0;
      bus.execute_ghr_i        = '0;
      bus.execute_taken_i      = 1'b0;
      bus.execute_target_i     = '0;
      bus.execute_mispredict_i = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic fetch(input logic [31:0] pc, input logic hit, input logic taken,
                        input logic [31:0] target, input logic [GHR_BITS-1:0] ghr,
                        input string name);
      exp_t e;
      e.hit    = hit;
      e.taken  = taken;
      e.target = target;
      e.ghr    = ghr;
      e.name   = name;
      exp_q.push_back(e);
      bus.fetch_valid_i = 1'b1;
      bus.fetch_pc_i    = pc;
   endtask

   task automatic update(input logic [31:0] pc, input logic [GHR_BITS-1:0] ghr,
                         input logic taken, input logic [31:0] target, input logic mispredict);
      bus.execute_valid_i      = 1'b1;
      bus.execute_pc_i         = pc;
      bus.execute_ghr_i        = ghr;
      bus.execute_taken_i      = taken;
      bus.execute_target_i     = target;
      bus.execute_mispredict_i = mispredict;
   endtask

   // Not-taken repair from an unrelated PC (PHT index 0x00): forces GHR back to 0.
   task automatic clear_ghr();
      update(32'h1000, 8'h00, 1'b0, 32'h0, 1'b1);
      tick();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      fetch(32'h100, 1'b0, 1'b0, 32'h104, 8'h00, "t1_reset_state"); tick();

      // Train pc 0x100 to strongly taken, then speculative history shift
      repeat (2) begin update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0); tick(); end
      fetch(32'h100, 1'b1, 1'b1, 32'h80, 8'h00, "t2_hit_taken"); tick();
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h01, "t2_ghr_shifted"); tick();

      // Reset mid-operation with an update in the reset cycle (GHR was 0x02)
      rst_n = 1'b0;
      update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0);
      tick();
      rst_n = 1'b1;
      fetch(32'h100, 1'b0, 1'b0, 32'h104, 8'h00, "t6_btb_and_ghr_cleared"); tick();
      update(32'h100, 8'h01, 1'b1, 32'h80, 1'b0); tick();
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h00, "t6_pht_back_to_wnt"); tick();

      // Counter saturation at index 0x40
      repeat (5) begin update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0); tick(); end
      fetch(32'h100, 1'b1, 1'b1, 32'h80, 8'h00, "t3_sat_high"); tick();
      clear_ghr();
      update(32'h100, 8'h00, 1'b0, 32'h0, 1'b0); tick();
      fetch(32'h100, 1'b1, 1'b1, 32'h80, 8'h00, "t3_one_not_taken"); tick();
      clear_ghr();
      repeat (2) begin update(32'h100, 8'h00, 1'b0, 32'h0, 1'b0); tick(); end
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h00, "t3_not_taken_hit"); tick();
      update(32'h100, 8'h00, 1'b0, 32'h0, 1'b0); tick();
      update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0); tick();
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h00, "t3_sat_low"); tick();

      // Same-cycle fetch/update collision: fetch sees the pre-update counter
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h00, "t7_collision_old");
      update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0);
      tick();
      fetch(32'h100, 1'b1, 1'b1, 32'h80, 8'h00, "t7_collision_new"); tick();

      // Repair has priority over the speculative shift
      fetch(32'h100, 1'b1, 1'b1, 32'h80, 8'h01, "t4_setup_ghr"); tick();
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h03, "t4_before_repair");
      update(32'h1000, 8'h05, 1'b0, 32'h0, 1'b1);
      tick();
      fetch(32'h100, 1'b1, 1'b0, 32'h104, 8'h0A, "t4_repair_priority"); tick();
      clear_ghr();

      // BTB conflict at index 0, then PC+4 wrap
      update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0); tick();
      update(32'h200, 8'h00, 1'b1, 32'h300, 1'b0); tick();
      fetch(32'h100, 1'b0, 1'b0, 32'h104, 8'h00, "t5_evicted_miss"); tick();
      fetch(32'h200, 1'b1, 1'b1, 32'h300, 8'h00, "t5_new_tag_hit"); tick();
      fetch(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 8'h01, "t5_target_wrap"); tick();

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised next-generation direction and target predictor for the superscalar fetch stage. It replaces the PC-indexed bimodal table with a gshare pattern history table (PC XOR speculative global history) and adds a direct-mapped branch target buffer (BTB), so fetch gets both direction and target in the same cycle. Execute-stage resolution trains both tables and repairs the speculative history on mispredict.

Parameters:
PHT_ENTRIES, 256, pattern history table depth; power of two, at least 4
CTR_BITS, 2, saturating counter width; at least 1
GHR_BITS, 8, global history length; at most log2(PHT_ENTRIES)
BTB_ENTRIES, 64, BTB depth; power of two, at least 2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fetch_valid_i  in  1  fetch PC valid this cycle
fetch_pc_i  in  32  fetch PC
predict_taken_o  out  1  predicted taken
predict_target_o  out  32  predicted next PC
btb_hit_o  out  1  BTB tag match for fetch_pc_i
predict_ghr_o  out  GHR_BITS  GHR snapshot used for this prediction; travels down the pipe
execute_valid_i  in  1  resolved conditional branch in execute
execute_pc_i  in  32  PC of resolved branch
execute_ghr_i  in  GHR_BITS  snapshot captured at its fetch
execute_taken_i  in  1  actual outcome
execute_target_i  in  32  actual taken target
execute_mispredict_i  in  1  direction or target mispredicted; qualified by execute_valid_i

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n); the polarity and synchronicity are fixed.
- Reset (rst_n=0 at clk edge): every PHT counter set to weakly-not-taken, 2^(CTR_BITS-1)-1 (01 for 2 bits). All BTB valid bits cleared. GHR cleared to 0. Updates presented in the reset cycle are discarded.
- Outputs are combinational from fetch_pc_i and the state registers (0-cycle prediction latency). After reset: btb_hit_o=0, predict_taken_o=0, predict_target_o=fetch_pc_i+4, predict_ghr_o=0.
- Index rules: IDX=log2(PHT_ENTRIES). pht_idx = pc[IDX+1:2] XOR zero-extended ghr. btb_idx = pc[log2(BTB_ENTRIES)+1:2]. The BTB tag is pc[31:log2(BTB_ENTRIES)+2]. pc[1:0] is ignored.
- Prediction: btb_hit_o = valid & tag match. predict_taken_o = btb_hit_o & counter MSB. predict_target_o = predict_taken_o ? BTB target : fetch_pc_i+4 (32-bit wrap). predict_ghr_o = current GHR.
- Speculative GHR: if fetch_valid_i & btb_hit_o and no mispredict repair this cycle, GHR <= {GHR[GHR_BITS-2:0], predict_taken_o}. For GHR_BITS=1, GHR <= predict_taken_o.
- Repair: if execute_valid_i & execute_mispredict_i, GHR <= {execute_ghr_i[GHR_BITS-2:0], execute_taken_i}. Repair has priority over the speculative shift in the same cycle.
- PHT training: on execute_valid_i, update the counter at the index formed from execute_pc_i and execute_ghr_i (not the current GHR). Taken increments, saturating at all-ones; not-taken decrements, saturating at 0.
- BTB training: on execute_valid_i & execute_taken_i, write valid=1, tag, and execute_target_i at btb_idx, overwriting any other tag (no replacement policy). Not-taken branches never allocate or invalidate entries.
- Read/write collision: when a fetch and an update hit the same PHT or BTB entry in one cycle, the fetch sees the pre-update value. There is no bypass.
- Single update port: at most one resolution per cycle.

Decomposition:
- Package bp_pkg holds:
  - sat_inc and sat_dec functions, parametrised by width
  - weakly-not-taken init constant function
  - btb_entry_t struct {valid, tag, target}, with tag width passed as a parameter
- Sub-module branch_target_buffer: BTB array, tag compare, and write port, instantiated once. PHT and GHR logic stay in the top module.

Test Plan:
1. Reset, then fetch_pc_i=0x100 -> btb_hit_o=0, predict_taken_o=0, predict_target_o=0x104, predict_ghr_o=0x00.
2. Two taken updates (pc 0x100, ghr 0x00, target 0x80, mispredict=0) with fetch idle. Then fetch 0x100 -> hit=1, taken=1, target=0x80, predict_ghr_o=0x00. Next cycle, GHR=0x01.
3. Counter saturation at pc 0x100, ghr 0: five taken updates -> counter 11. One not-taken -> still predicts taken (10). Two more not-taken -> 00, predicts not-taken, target 0x104 while the BTB still hits.
4. Repair priority: GHR=0x03 while fetch_valid_i & btb_hit_o. In the same cycle, execute_valid_i=1, mispredict=1, ghr_i=0x05, taken=0 -> next-cycle GHR=0x0A, not 0x07.
5. BTB conflict: taken update pc 0x100 target 0x80, then taken update pc 0x200 (same btb_idx 0) target 0x300 -> fetch 0x100 misses (target 0x104); fetch 0x200 hits, target 0x300.
6. Reset mid-operation: after test 2, hold rst_n=0 for one edge while a taken update is applied -> fetch 0x100 misses, GHR=0, counter at index 0x40 is back to 01.
7. Same-cycle collision: fetch 0x100 while the counter is 01 and a taken update to the same index is applied -> that cycle predicts not-taken; the next cycle predicts taken.
